// File: rtl/lcd_nibble_writer_pkg.sv
// Shared definitions for the 4-bit character LCD bus driver: FSM states,
// default bus timing (in 50 MHz clock cycles) and HD44780 command codes.
package lcd_nibble_writer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SETUP_H,
    PULSE_H,
    HOLD_H,
    GAP,
    SETUP_L,
    PULSE_L,
    HOLD_L,
    EXEC
  } state_t;

  localparam int CNT_W = 17;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 12;
  localparam int T_HOLD_DEF  = 1;
  localparam int T_GAP_DEF   = 50;
  localparam int T_EXEC_DEF  = 2000;
  localparam int T_CLEAR_DEF = 82000;

  typedef enum logic [7:0] {
    CMD_CLEAR     = 8'h01,
    CMD_HOME      = 8'h02,
    CMD_ENTRY     = 8'h06,
    CMD_DISP_ON   = 8'h0C,
    CMD_FUNC_4BIT = 8'h28,
    CMD_DDRAM_0   = 8'h80
  } lcd_cmd_t;

  // 0x03 decodes as return-home on the controller (bit 0 is don't-care).
  function automatic logic is_slow_cmd(input logic [7:0] code);
    return (code == CMD_CLEAR) || (code == CMD_HOME) || (code == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that stops at zero; shared by the nibble writer
// and the power-on sequencer for its long waits.
module lcd_delay_counter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Serialises one command/data byte (or a single init nibble) onto the 4-bit
// LCD bus with E strobes, then waits out the controller execution time.
module lcd_nibble_writer
  import lcd_nibble_writer_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF,
  parameter int T_EXEC  = T_EXEC_DEF,
  parameter int T_CLEAR = T_CLEAR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       rs,
  input  logic       nib_only,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic [3:0] lcd_d,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  state_t             state_reg, state_next;
  logic [7:0]         data_reg;
  logic               rs_reg, nib_reg;
  logic               done_reg, done_next;
  logic               load;
  logic [CNT_W-1:0]   load_value, count;
  logic               count_zero;
  logic               slow_wait;

  lcd_delay_counter #(.W(CNT_W)) u_delay (
    .clk        (clk),
    .rst        (reset),
    .load       (load),
    .load_value (load_value),
    .value      (count),
    .zero       (count_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      rs_reg    <= 1'b0;
      nib_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      if (state_reg == IDLE && wr_en) begin
        data_reg <= data;
        rs_reg   <= rs;
        nib_reg  <= nib_only;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE:    if (wr_en) state_next = nib_only ? SETUP_L : SETUP_H;
      SETUP_H: if (count_zero) state_next = PULSE_H;
      PULSE_H: if (count_zero) state_next = HOLD_H;
      HOLD_H:  if (count_zero) state_next = GAP;
      GAP:     if (count_zero) state_next = SETUP_L;
      SETUP_L: if (count_zero) state_next = PULSE_L;
      PULSE_L: if (count_zero) state_next = HOLD_L;
      HOLD_L:  if (count_zero) state_next = EXEC;
      EXEC: begin
        if (count_zero) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign slow_wait = !rs_reg && !nib_reg && is_slow_cmd(data_reg);

  // Every state entry reloads the counter so each state lasts exactly its count.
  always_comb begin
    load       = (state_next != state_reg);
    load_value = '0;
    case (state_next)
      SETUP_H, SETUP_L: load_value = CNT_W'(T_SETUP - 1);
      PULSE_H, PULSE_L: load_value = CNT_W'(T_PULSE - 1);
      HOLD_H,  HOLD_L:  load_value = CNT_W'(T_HOLD - 1);
      GAP:              load_value = CNT_W'(T_GAP - 1);
      EXEC:             load_value = slow_wait ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_EXEC - 1);
      default:          load_value = '0;
    endcase
  end

  always_comb begin
    lcd_d  = '0;
    lcd_rs = 1'b0;
    case (state_reg)
      SETUP_H, PULSE_H, HOLD_H, GAP: begin
        lcd_d  = data_reg[7:4];
        lcd_rs = rs_reg;
      end
      SETUP_L, PULSE_L, HOLD_L: begin
        lcd_d  = data_reg[3:0];
        lcd_rs = rs_reg;
      end
      default: ;
    endcase
  end

  // Decoded straight from the async-reset state so E drops the instant reset rises.
  assign lcd_e  = (state_reg == PULSE_H) || (state_reg == PULSE_L);
  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Scoreboard bench for lcd_nibble_writer: expected E pulses and done cycles
// are queued when a write is accepted and consumed as the bus activity appears.
module tb_lcd_nibble_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       rs = 1'b0;
  logic       nib_only = 1'b0;
  logic [7:0] data = 8'h00;
  logic       busy, done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  always #10 clk = ~clk;

  lcd_nibble_writer dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .rs       (rs),
    .nib_only (nib_only),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .lcd_d    (lcd_d),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw)
  );

  typedef struct packed {
    int         start;
    logic [3:0] nib;
    logic       rs;
  } pulse_t;

  pulse_t pq[$];
  int     dq[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int busy_from = 0;
  int idle_at = 0;
  int n_acc = 0;

  // Monitor-only state
  pulse_t cur = '0;
  logic   e_act = 1'b0;
  int     e_w = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Interval c ends with the accepting edge; cycle k of the transfer is interval c+k.
  task automatic model_accept(input logic [7:0] d, input logic r, input logic n, input int c);
    int len;
    if (n) len = 2015;
    else if (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) len = 82080;
    else len = 2080;
    if (n) begin
      pq.push_back('{c + 3, d[3:0], r});
    end else begin
      pq.push_back('{c + 3, d[7:4], r});
      pq.push_back('{c + 68, d[3:0], r});
    end
    dq.push_back(c + len + 1);
    busy_from = c + 1;
    idle_at   = c + len + 1;
    n_acc++;
    $display("write #%0d data=%02h rs=%0b nib_only=%0b accepted at interval %0d, busy %0d cycles",
             n_acc, d, r, n, c, len);
  endtask

  task automatic step(input logic we, input logic [7:0] d, input logic r, input logic n);
    @(negedge clk);
    wr_en    = we;
    data     = d;
    rs       = r;
    nib_only = n;
    if (we && !reset && cyc >= idle_at) model_accept(d, r, n, cyc);
  endtask

  task automatic write_hold(input logic [7:0] d, input logic r, input logic n);
    int a;
    a = n_acc;
    while (n_acc == a) step(1'b1, d, r, n);
  endtask

  task automatic wait_idle();
    while (cyc <= idle_at) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    check_value("busy", busy, (cyc >= busy_from && cyc < idle_at));
    if (done) begin
      if (dq.size() == 0) begin
        check_value("done_unexpected", done, 1'b0);
      end else begin
        check_value("done_cycle", cyc, dq[0]);
        $display("done observed at interval %0d", cyc);
        void'(dq.pop_front());
      end
    end
    if (dq.size() != 0 && dq[0] < cyc) begin
      check_value("done_missing", cyc, dq[0]);
      void'(dq.pop_front());
    end
    if (reset) begin
      e_act = 1'b0;
    end else begin
      if (lcd_e && !e_act) begin
        e_act = 1'b1;
        e_w   = 0;
        if (pq.size() == 0) begin
          check_value("pulse_unexpected", lcd_e, 1'b0);
        end else begin
          cur = pq.pop_front();
          check_value("pulse_start", cyc, cur.start);
        end
        check_value("lcd_rw", lcd_rw, 1'b0);
      end
      if (lcd_e) begin
        e_w++;
        check_value("pulse_d", lcd_d, cur.nib);
        check_value("pulse_rs", lcd_rs, cur.rs);
      end else if (e_act) begin
        e_act = 1'b0;
        check_value("pulse_width", e_w, 12);
        check_value("hold_d", lcd_d, cur.nib);
        check_value("hold_rs", lcd_rs, cur.rs);
      end
      if (pq.size() != 0 && pq[0].start < cyc) begin
        check_value("pulse_missing", cyc, pq[0].start);
        void'(pq.pop_front());
      end
    end
  end

  initial begin
    int a;
    int acc_c;

    repeat (2) @(negedge clk);
    #1;
    check_value("rst_busy", busy, 1'b0);
    check_value("rst_done", done, 1'b0);
    check_value("rst_lcd_e", lcd_e, 1'b0);
    check_value("rst_lcd_d", lcd_d, 4'h0);
    check_value("rst_lcd_rs", lcd_rs, 1'b0);
    check_value("rst_lcd_rw", lcd_rw, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle_at = cyc;
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);

    write_hold(8'h28, 1'b0, 1'b0);
    wait_idle();
    write_hold(8'h01, 1'b0, 1'b0);
    wait_idle();
    write_hold(8'h41, 1'b1, 1'b0);
    wait_idle();
    write_hold(8'h03, 1'b0, 1'b1);
    wait_idle();

    // Abandon a byte in the middle of its lower-nibble E pulse.
    write_hold(8'h80, 1'b0, 1'b0);
    acc_c = idle_at - 2081;
    while (cyc < acc_c + 70) step(1'b0, 8'h00, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_value("abort_lcd_e", lcd_e, 1'b0);
    check_value("abort_busy", busy, 1'b0);
    check_value("abort_done", done, 1'b0);
    pq.delete();
    dq.delete();
    idle_at   = cyc;
    busy_from = cyc;
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_value("release_busy", busy, 1'b0);
    repeat (20) step(1'b0, 8'h00, 1'b0, 1'b0);

    // wr_en held high with fresh data every cycle; only done-cycle bytes may be taken.
    a = n_acc;
    while (n_acc < a + 2) step(1'b1, {1'b1, 7'($urandom)}, 1'b0, 1'b0);
    wait_idle();
    repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);

    check_value("pulses_outstanding", pq.size(), 0);
    check_value("dones_outstanding", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
